// File: rtl/len5_pkg.sv
// Shared fetch-side types and constants: instruction/address widths, the
// instruction-cache line layout and the per-entry record of the fetch
// line buffer.
package len5_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned ILEN          = 32;
    localparam int unsigned OFFSET        = 2;   // byte offset bits of one instruction
    localparam int unsigned ICACHE_OFFSET = 4;   // instruction-index bits within a line
    localparam int unsigned ICACHE_INSTR  = 2**ICACHE_OFFSET;

    // One line as delivered by the instruction cache
    typedef struct packed {
        logic [XLEN-1:0]                   pc;
        logic [ICACHE_INSTR-1:0][ILEN-1:0] line;
    } icache_out_t;

    // One buffered line plus the index of the next instruction to hand out
    typedef struct packed {
        logic [ICACHE_INSTR-1:0][ILEN-1:0] line;
        logic [XLEN-1:0]                   pc;
        logic [ICACHE_OFFSET-1:0]          offset;
    } fetch_entry_t;

    // Index of the instruction addressed by pc inside its line
    function automatic logic [ICACHE_OFFSET-1:0] line_start_offset(input logic [XLEN-1:0] pc);
        return pc[ICACHE_OFFSET+OFFSET-1:OFFSET];
    endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// Fetch line buffer: small circular FIFO of instruction-cache lines that
// hands instructions to decode one at a time, starting at the offset of
// the fetched PC and dropping the rest of a line on a predicted-taken
// branch. The LINE_INSTR parameter must match the package line width.
module fetch_line_buffer
    import len5_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LINE_INSTR = 2**ICACHE_OFFSET
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            line_valid_i,
    output logic            line_ready_o,
    input  icache_out_t     line_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instruction_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            pred_taken_i
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OFFS_W = $clog2(LINE_INSTR);

    // Clears the instruction-index and byte-offset bits of a line PC
    localparam logic [XLEN-1:0] LINE_BASE_MASK =
        ~((XLEN'(1) << (OFFS_W + OFFSET)) - XLEN'(1));

    fetch_entry_t     buf_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    fetch_entry_t head_s;
    fetch_entry_t new_entry_s;
    logic         full_s;
    logic         empty_s;
    logic         push_s;
    logic         cons_s;
    logic         pop_s;
    logic         last_slot_s;

    assign head_s  = buf_r[head_r];
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Outputs depend only on registered state: no bypass in either direction
    assign line_ready_o  = !full_s;
    assign instr_valid_o = !empty_s;
    assign instruction_o = head_s.line[head_s.offset];
    assign instr_pc_o    = (head_s.pc & LINE_BASE_MASK) | (XLEN'(head_s.offset) << OFFSET);

    // Handshake decode; a flush suppresses both push and consume
    always_comb begin
        push_s      = 1'b0;
        cons_s      = 1'b0;
        pop_s       = 1'b0;
        last_slot_s = (head_s.offset == ICACHE_OFFSET'(LINE_INSTR - 1));
        if (!flush_i) begin
            push_s = line_valid_i && !full_s;
            cons_s = !empty_s && instr_ready_i;
            pop_s  = cons_s && (last_slot_s || pred_taken_i);
        end else begin
            push_s = 1'b0;
            cons_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Build the entry written at the tail, starting at the fetched PC's slot
    always_comb begin
        new_entry_s        = '0;
        new_entry_s.line   = line_i.line;
        new_entry_s.pc     = line_i.pc;
        new_entry_s.offset = line_start_offset(line_i.pc);
    end

    // FIFO storage, pointers and occupancy; flush has priority over push/consume
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                buf_r[tail_r] <= new_entry_s;
                tail_r        <= tail_r + PTR_W'(1);
            end
            // When not empty and not full head and tail differ, so the
            // offset bump never collides with the tail write
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else if (cons_s) begin
                buf_r[head_r].offset <= head_s.offset + ICACHE_OFFSET'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed scenarios plus random traffic,
// checked against a queue-of-instructions reference model.
module tb_fetch_line_buffer;
    import len5_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            line_valid_i;
    logic            line_ready_o;
    icache_out_t     line_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [ILEN-1:0] instruction_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            pred_taken_i;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    fetch_line_buffer #(.DEPTH(2), .LINE_INSTR(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .line_valid_i(line_valid_i), .line_ready_o(line_ready_o), .line_i(line_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instruction_o(instruction_o), .instr_pc_o(instr_pc_o),
        .pred_taken_i(pred_taken_i)
    );

    // Reference model: every pending instruction in hand-out order, tagged by line
    typedef struct {
        int          tag;
        logic [63:0] pc;
        logic [31:0] instr;
        bit          last;
    } exp_t;

    exp_t        mq[$];
    int          m_lines = 0;
    int          m_tag   = 0;
    logic [63:0] seen_pc[$];

    function automatic icache_out_t mk_line(input logic [63:0] pc);
        icache_out_t l;
        l.pc = pc;
        for (int k = 0; k < 16; k++) l.line[k] = $urandom;
        return l;
    endfunction

    task automatic apply(input logic lv, input icache_out_t ln, input logic ir,
                         input logic pt, input logic fl);
        line_valid_i  = lv;
        line_i        = ln;
        instr_ready_i = ir;
        pred_taken_i  = pt;
        flush_i       = fl;
        #1;
    endtask

    // Update the model with this cycle's inputs, then move to the next cycle
    task automatic advance();
        bit   cons, push;
        exp_t e;
        if (flush_i) begin
            mq.delete();
            m_lines = 0;
        end else begin
            cons = (mq.size() != 0) && instr_ready_i;
            push = line_valid_i && (m_lines < 2);
            if (cons) begin
                e = mq.pop_front();
                seen_pc.push_back(e.pc);
                if (pred_taken_i && !e.last)
                    while (mq.size() != 0 && mq[0].tag == e.tag) mq.delete(0);
                if (pred_taken_i || e.last) m_lines--;
            end
            if (push) begin
                for (int k = int'(line_i.pc[5:2]); k < 16; k++) begin
                    exp_t n;
                    n.tag   = m_tag;
                    n.pc    = (line_i.pc & ~64'h3F) + 64'(k * 4);
                    n.instr = line_i.line[k];
                    n.last  = (k == 15);
                    mq.push_back(n);
                end
                m_tag++;
                m_lines++;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        mq.delete();
        m_lines = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        tests_run++;
        if (instr_valid_o !== 1'b0 || line_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_handshake: valid=%0b ready=%0b, want valid=0 ready=1", instr_valid_o, line_ready_o);
        end
        tests_run++;
        if (instruction_o !== 32'h0 || instr_pc_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data: instr=%h pc=%h, want 0/0", instruction_o, instr_pc_o);
        end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential_drain();
        seen_pc.delete();
        for (int c = 0; c < 19; c++) begin
            if (c == 0) apply(1'b1, mk_line(64'h1000), 1'b1, 1'b0, 1'b0);
            else        apply(1'b0, line_i, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (instr_valid_o !== (mq.size() != 0) || line_ready_o !== (m_lines < 2)) begin
                tests_failed++;
                $display("FAIL drain_handshake c=%0d: valid=%0b ready=%0b, want %0b/%0b", c, instr_valid_o, line_ready_o, mq.size() != 0, m_lines < 2);
            end
            if (mq.size() != 0) begin
                tests_run++;
                if (instr_pc_o !== mq[0].pc || instruction_o !== mq[0].instr) begin
                    tests_failed++;
                    $display("FAIL drain_data c=%0d: pc=%h instr=%h, want %h/%h", c, instr_pc_o, instruction_o, mq[0].pc, mq[0].instr);
                end
            end
            advance();
        end
        tests_run++;
        if (seen_pc.size() != 16) begin
            tests_failed++;
            $display("FAIL drain_count: got %0d instructions, want 16", seen_pc.size());
        end
        for (int i = 0; i < seen_pc.size() && i < 16; i++) begin
            tests_run++;
            if (seen_pc[i] !== 64'h1000 + 64'(4 * i)) begin
                tests_failed++;
                $display("FAIL drain_pc[%0d]: got %h, want %h", i, seen_pc[i], 64'h1000 + 64'(4 * i));
            end
        end
        tests_run++;
        if (instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: valid=%0b, want 0", instr_valid_o);
        end
    endtask

    task automatic test_mid_line();
        seen_pc.delete();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) apply(1'b1, mk_line(64'h2038), 1'b1, 1'b0, 1'b0);
            else        apply(1'b0, line_i, 1'b1, 1'b0, 1'b0);
            if (mq.size() != 0) begin
                tests_run++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== mq[0].pc || instruction_o !== mq[0].instr) begin
                    tests_failed++;
                    $display("FAIL midline_data c=%0d: valid=%0b pc=%h instr=%h, want 1/%h/%h", c, instr_valid_o, instr_pc_o, instruction_o, mq[0].pc, mq[0].instr);
                end
            end
            advance();
        end
        tests_run++;
        if (seen_pc.size() != 2 || seen_pc[0] !== 64'h2038 || seen_pc[1] !== 64'h203C) begin
            tests_failed++;
            $display("FAIL midline_pcs: got %0d instrs, want 2 (2038,203c)", seen_pc.size());
        end
        tests_run++;
        if (instr_valid_o !== 1'b0 || line_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midline_pop: valid=%0b ready=%0b, want 0/1", instr_valid_o, line_ready_o);
        end
    endtask

    task automatic test_taken_branch();
        logic pt;
        seen_pc.delete();
        for (int c = 0; c < 18; c++) begin
            pt = (seen_pc.size() == 2) && (mq.size() != 0);
            if (c == 0)      apply(1'b1, mk_line(64'h3000), 1'b1, pt, 1'b0);
            else if (c == 1) apply(1'b1, mk_line(64'h4010), 1'b1, pt, 1'b0);
            else             apply(1'b0, line_i, 1'b1, pt, 1'b0);
            if (mq.size() != 0) begin
                tests_run++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== mq[0].pc || instruction_o !== mq[0].instr) begin
                    tests_failed++;
                    $display("FAIL taken_data c=%0d: valid=%0b pc=%h, want 1/%h", c, instr_valid_o, instr_pc_o, mq[0].pc);
                end
            end
            advance();
        end
        tests_run++;
        if (seen_pc.size() != 15 || seen_pc[3] !== 64'h4010) begin
            tests_failed++;
            $display("FAIL taken_redirect: %0d instrs, 4th pc=%h, want 15 and 4010", seen_pc.size(), (seen_pc.size() > 3) ? seen_pc[3] : 64'h0);
        end
    endtask

    task automatic test_backpressure();
        icache_out_t lc;
        bit          got_ready;
        lc = mk_line(64'h7000);
        seen_pc.delete();
        apply(1'b1, mk_line(64'h5000), 1'b0, 1'b0, 1'b0); advance();
        apply(1'b1, mk_line(64'h6000), 1'b0, 1'b0, 1'b0); advance();
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, lc, 1'b0, 1'b0, 1'b0);
            tests_run++;
            if (line_ready_o !== 1'b0 || instr_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_ready c=%0d: ready=%0b valid=%0b, want 0/1", c, line_ready_o, instr_valid_o);
            end
            advance();
        end
        got_ready = 1'b0;
        for (int c = 0; c < 40 && !got_ready; c++) begin
            apply(1'b1, lc, 1'b1, 1'b0, 1'b0);
            if (line_ready_o === 1'b1) begin
                got_ready = 1'b1;
                tests_run++;
                if (seen_pc.size() != 16) begin
                    tests_failed++;
                    $display("FAIL full_release: ready after %0d consumes, want 16", seen_pc.size());
                end
            end
            advance();
        end
        if (!got_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL full_timeout: line_ready_o=0 after 40 cycles, want 1");
        end
        for (int c = 0; c < 40; c++) begin
            apply(1'b0, lc, 1'b1, 1'b0, 1'b0);
            if (mq.size() != 0) begin
                tests_run++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== mq[0].pc || instruction_o !== mq[0].instr) begin
                    tests_failed++;
                    $display("FAIL full_drain c=%0d: pc=%h, want %h", c, instr_pc_o, mq[0].pc);
                end
            end
            advance();
        end
        tests_run++;
        if (seen_pc.size() != 48 || instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_total: %0d instrs valid=%0b, want 48/0", seen_pc.size(), instr_valid_o);
        end
    endtask

    task automatic test_flush();
        apply(1'b1, mk_line(64'h8000), 1'b0, 1'b0, 1'b0); advance();
        apply(1'b1, mk_line(64'h9000), 1'b0, 1'b0, 1'b0); advance();
        apply(1'b1, mk_line(64'hA000), 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || line_ready_o !== 1'b0 || instr_pc_o !== 64'h8000) begin
            tests_failed++;
            $display("FAIL flush_pre: valid=%0b ready=%0b pc=%h, want 1/0/8000", instr_valid_o, line_ready_o, instr_pc_o);
        end
        advance();
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, line_i, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (instr_valid_o !== 1'b0 || line_ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL flush_post c=%0d: valid=%0b ready=%0b, want 0/1", c, instr_valid_o, line_ready_o);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [63:0] pc;
        for (int c = 0; c < 400; c++) begin
            pc = {$urandom, $urandom} & ~64'h3;
            apply(($urandom % 3) != 0, mk_line(pc), ($urandom % 4) != 0,
                  ($urandom % 8) == 0, ($urandom % 32) == 0);
            tests_run++;
            if (instr_valid_o !== (mq.size() != 0) || line_ready_o !== (m_lines < 2)) begin
                tests_failed++;
                $display("FAIL random_handshake c=%0d: valid=%0b ready=%0b, want %0b/%0b", c, instr_valid_o, line_ready_o, mq.size() != 0, m_lines < 2);
            end
            if (mq.size() != 0) begin
                tests_run++;
                if (instr_pc_o !== mq[0].pc || instruction_o !== mq[0].instr) begin
                    tests_failed++;
                    $display("FAIL random_data c=%0d: pc=%h instr=%h, want %h/%h", c, instr_pc_o, instruction_o, mq[0].pc, mq[0].instr);
                end
            end
            advance();
        end
        apply(1'b0, line_i, 1'b0, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_reset_mid();
        apply(1'b1, mk_line(64'hB000), 1'b0, 1'b0, 1'b0); advance();
        apply(1'b0, line_i, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (instr_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_setup: valid=%0b, want 1", instr_valid_o);
        end
        #1 rst_i = 1'b1;
        #1;
        tests_run++;
        if (instr_valid_o !== 1'b0 || line_ready_o !== 1'b1 || instruction_o !== 32'h0 || instr_pc_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL rstmid_async: valid=%0b ready=%0b instr=%h pc=%h, want 0/1/0/0", instr_valid_o, line_ready_o, instruction_o, instr_pc_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        apply(1'b1, mk_line(64'hC008), 1'b0, 1'b0, 1'b0);
        advance();
        apply(1'b0, line_i, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 64'hC008 || instruction_o !== line_i.line[2]) begin
            tests_failed++;
            $display("FAIL rstmid_first_push: valid=%0b pc=%h, want 1/c008", instr_valid_o, instr_pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_drain();
        test_mid_line();
        test_taken_branch();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
